// File: rtl/rf_read_stage.sv
// Two-read/one-write register file with write-through bypass, ID/EX operand
// pipeline register and load-use hazard detection with a saturating stall counter.
module rf_read_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            RFWr,
    input  logic [AW-1:0]   A3,
    input  logic [XLEN-1:0] WD,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    input  logic            use_rs1,
    input  logic            use_rs2,
    input  logic            ex_memread,
    input  logic [AW-1:0]   ex_rd,
    input  logic            flush,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    output logic [XLEN-1:0] RD1_q,
    output logic [XLEN-1:0] RD2_q,
    output logic [AW-1:0]   rs1_q,
    output logic [AW-1:0]   rs2_q,
    output logic            stall,
    output logic [31:0]     stall_cnt
);

    logic [XLEN-1:0] rf_r [NREG];
    logic [XLEN-1:0] rd1_s;
    logic [XLEN-1:0] rd2_s;
    logic            stall_s;
    logic            bubble_s;
    logic            wr_en_s;
    logic [XLEN-1:0] rd1_q_r;
    logic [XLEN-1:0] rd2_q_r;
    logic [AW-1:0]   rs1_q_r;
    logic [AW-1:0]   rs2_q_r;
    logic [31:0]     stall_cnt_r;

    // x0 is never written, so its array entry stays at its reset value of zero
    assign wr_en_s = RFWr && (A3 != {AW{1'b0}});

    // Register array: cleared by reset, written from writeback
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) begin
                rf_r[i] <= {XLEN{1'b0}};
            end
        end else if (wr_en_s) begin
            rf_r[A3] <= WD;
        end
    end

    // Read port 1: x0 forced to zero, then same-cycle write-through, then array
    always_comb begin
        rd1_s = {XLEN{1'b0}};
        if (A1 == {AW{1'b0}}) begin
            rd1_s = {XLEN{1'b0}};
        end else if (RFWr && (A3 == A1)) begin
            rd1_s = WD;
        end else begin
            rd1_s = rf_r[A1];
        end
    end

    // Read port 2: same priority as port 1
    always_comb begin
        rd2_s = {XLEN{1'b0}};
        if (A2 == {AW{1'b0}}) begin
            rd2_s = {XLEN{1'b0}};
        end else if (RFWr && (A3 == A2)) begin
            rd2_s = WD;
        end else begin
            rd2_s = rf_r[A2];
        end
    end

    // Load in EX whose destination is a source actually used by ID
    assign stall_s  = ex_memread && (ex_rd != {AW{1'b0}}) &&
                      ((use_rs1 && (ex_rd == A1)) || (use_rs2 && (ex_rd == A2)));
    assign bubble_s = flush || stall_s;

    // ID/EX operand register: bubble (all zero) on flush or stall
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd1_q_r <= {XLEN{1'b0}};
            rd2_q_r <= {XLEN{1'b0}};
            rs1_q_r <= {AW{1'b0}};
            rs2_q_r <= {AW{1'b0}};
        end else if (bubble_s) begin
            rd1_q_r <= {XLEN{1'b0}};
            rd2_q_r <= {XLEN{1'b0}};
            rs1_q_r <= {AW{1'b0}};
            rs2_q_r <= {AW{1'b0}};
        end else begin
            rd1_q_r <= rd1_s;
            rd2_q_r <= rd2_s;
            rs1_q_r <= A1;
            rs2_q_r <= A2;
        end
    end

    // Saturating stall-cycle counter; flush alone does not count
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign RD1       = rd1_s;
    assign RD2       = rd2_s;
    assign stall     = stall_s;
    assign RD1_q     = rd1_q_r;
    assign RD2_q     = rd2_q_r;
    assign rs1_q     = rs1_q_r;
    assign rs2_q     = rs2_q_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_rf_read_stage.sv
// Self-checking bench for rf_read_stage: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_rf_read_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        RFWr;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic [4:0]  A1, A2;
    logic        use_rs1, use_rs2, ex_memread;
    logic [4:0]  ex_rd;
    logic        flush;
    logic [31:0] RD1, RD2, RD1_q, RD2_q;
    logic [4:0]  rs1_q, rs2_q;
    logic        stall;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_rf [32];
    logic [31:0] m_rd1_q, m_rd2_q, m_cnt;
    logic [4:0]  m_rs1_q, m_rs2_q;

    rf_read_stage dut (
        .clk(clk), .rstn(rstn), .RFWr(RFWr), .A3(A3), .WD(WD),
        .A1(A1), .A2(A2), .use_rs1(use_rs1), .use_rs2(use_rs2),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .flush(flush),
        .RD1(RD1), .RD2(RD2), .RD1_q(RD1_q), .RD2_q(RD2_q),
        .rs1_q(rs1_q), .rs2_q(rs2_q), .stall(stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (RFWr && A3 == a) return WD;
        return m_rf[a];
    endfunction

    function automatic logic exp_stall();
        return ex_memread && ex_rd != 5'd0 &&
               ((use_rs1 && ex_rd == A1) || (use_rs2 && ex_rd == A2));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_rd1_q = 32'd0; m_rd2_q = 32'd0; m_rs1_q = 5'd0; m_rs2_q = 5'd0; m_cnt = 32'd0;
    endtask

    task automatic idle();
        RFWr = 1'b0; A3 = 5'd0; WD = 32'd0; A1 = 5'd0; A2 = 5'd0;
        use_rs1 = 1'b0; use_rs2 = 1'b0; ex_memread = 1'b0; ex_rd = 5'd0; flush = 1'b0;
    endtask

    // Advance one rising edge and update the model from the pre-edge inputs
    task automatic clk_edge();
        logic st, bub;
        logic [31:0] n1, n2;
        st = exp_stall(); bub = flush || st; n1 = exp_rd(A1); n2 = exp_rd(A2);
        @(posedge clk);
        if (RFWr && A3 != 5'd0) m_rf[A3] = WD;
        if (bub) begin
            m_rd1_q = 32'd0; m_rd2_q = 32'd0; m_rs1_q = 5'd0; m_rs2_q = 5'd0;
        end else begin
            m_rd1_q = n1; m_rd2_q = n2; m_rs1_q = A1; m_rs2_q = A2;
        end
        if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        #1;
    endtask

    task automatic test_reset();
        idle(); rstn = 1'b0; model_reset();
        #12;
        checks++; if (RD1_q !== 32'd0 || RD2_q !== 32'd0) begin errors++; $display("FAIL reset_rdq: got %h %h exp 0", RD1_q, RD2_q); end
        checks++; if (rs1_q !== 5'd0 || rs2_q !== 5'd0) begin errors++; $display("FAIL reset_rsq: got %0d %0d exp 0", rs1_q, rs2_q); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", stall_cnt); end
        @(posedge clk); #1; rstn = 1'b1; #1;
        checks++; if (stall !== 1'b0 || RD1 !== 32'd0) begin errors++; $display("FAIL reset_comb: stall %b rd1 %h exp 0 0", stall, RD1); end
    endtask

    task automatic test_write_read();
        idle(); RFWr = 1'b1; A3 = 5'd5; WD = 32'h1234_5678;
        clk_edge();
        idle(); A1 = 5'd5; use_rs1 = 1'b1; #1;
        checks++; if (RD1 !== 32'h1234_5678) begin errors++; $display("FAIL wr_rd1: got %h exp 12345678", RD1); end
        clk_edge();
        checks++; if (RD1_q !== 32'h1234_5678) begin errors++; $display("FAIL wr_rd1_q: got %h exp 12345678", RD1_q); end
        checks++; if (rs1_q !== 5'd5) begin errors++; $display("FAIL wr_rs1_q: got %0d exp 5", rs1_q); end
    endtask

    task automatic test_x0();
        idle(); RFWr = 1'b1; A3 = 5'd0; WD = 32'hFFFF_FFFF; A1 = 5'd0; #1;
        checks++; if (RD1 !== 32'd0) begin errors++; $display("FAIL x0_same: got %h exp 0", RD1); end
        clk_edge();
        idle(); #1;
        checks++; if (RD1 !== 32'd0 || RD1_q !== 32'd0) begin errors++; $display("FAIL x0_after: got %h %h exp 0 0", RD1, RD1_q); end
    endtask

    task automatic test_bypass();
        idle(); RFWr = 1'b1; A3 = 5'd7; WD = 32'hDEAD_BEEF; A2 = 5'd7; use_rs2 = 1'b1; #1;
        checks++; if (RD2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_rd2: got %h exp deadbeef", RD2); end
        clk_edge();
        checks++; if (RD2_q !== 32'hDEAD_BEEF || rs2_q !== 5'd7) begin errors++; $display("FAIL bypass_q: got %h/%0d exp deadbeef/7", RD2_q, rs2_q); end
    endtask

    task automatic test_load_use();
        idle(); ex_memread = 1'b1; ex_rd = 5'd3; A1 = 5'd3; use_rs1 = 1'b1; A2 = 5'd5; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b exp 1", stall); end
        clk_edge();
        checks++; if (RD1_q !== 32'd0 || RD2_q !== 32'd0 || rs1_q !== 5'd0 || rs2_q !== 5'd0) begin
            errors++; $display("FAIL lu_bubble: got %h %h %0d %0d exp all 0", RD1_q, RD2_q, rs1_q, rs2_q); end
        checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt: got %0d exp 1", stall_cnt); end
        use_rs1 = 1'b0; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_nouse: got %b exp 0", stall); end
        use_rs1 = 1'b1; ex_rd = 5'd0; A1 = 5'd0; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_x0: got %b exp 0", stall); end
        ex_rd = 5'd5; A1 = 5'd1; use_rs2 = 1'b1; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_rs2: got %b exp 1", stall); end
        flush = 1'b1;
        clk_edge();
        checks++; if (rs2_q !== 5'd0 || stall_cnt !== 32'd2) begin errors++; $display("FAIL lu_flush_both: got rs2_q %0d cnt %0d exp 0 2", rs2_q, stall_cnt); end
    endtask

    task automatic test_flush();
        idle(); A1 = 5'd5; use_rs1 = 1'b1; flush = 1'b1; #1;
        checks++; if (RD1 !== 32'h1234_5678) begin errors++; $display("FAIL fl_rd1: got %h exp 12345678", RD1); end
        clk_edge();
        checks++; if (RD1_q !== 32'd0 || rs1_q !== 5'd0) begin errors++; $display("FAIL fl_q: got %h/%0d exp 0/0", RD1_q, rs1_q); end
        checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL fl_cnt: got %0d exp 2", stall_cnt); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            RFWr       = ($urandom_range(0, 99) < 60);
            A3         = 5'($urandom_range(0, 7));
            WD         = $urandom;
            A1         = 5'($urandom_range(0, 7));
            A2         = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            use_rs1    = ($urandom_range(0, 3) != 0);
            use_rs2    = ($urandom_range(0, 1) != 0);
            ex_memread = ($urandom_range(0, 99) < 35);
            ex_rd      = 5'($urandom_range(0, 7));
            flush      = ($urandom_range(0, 9) == 0);
            #1;
            checks++; if (RD1 !== exp_rd(A1) || RD2 !== exp_rd(A2)) begin
                errors++; $display("FAIL rand_rd c%0d: got %h %h exp %h %h", c, RD1, RD2, exp_rd(A1), exp_rd(A2)); end
            checks++; if (stall !== exp_stall()) begin errors++; $display("FAIL rand_stall c%0d: got %b exp %b", c, stall, exp_stall()); end
            clk_edge();
            checks++; if (RD1_q !== m_rd1_q || RD2_q !== m_rd2_q || rs1_q !== m_rs1_q || rs2_q !== m_rs2_q) begin
                errors++; $display("FAIL rand_q c%0d: got %h %h %0d %0d exp %h %h %0d %0d", c, RD1_q, RD2_q, rs1_q, rs2_q, m_rd1_q, m_rd2_q, m_rs1_q, m_rs2_q); end
            checks++; if (stall_cnt !== m_cnt) begin errors++; $display("FAIL rand_cnt c%0d: got %0d exp %0d", c, stall_cnt, m_cnt); end
        end
    endtask

    task automatic test_async_reset();
        idle(); RFWr = 1'b1; A3 = 5'd5; WD = 32'hA5A5_0001; clk_edge();
        idle(); ex_memread = 1'b1; ex_rd = 5'd4; A1 = 5'd4; use_rs1 = 1'b1; clk_edge();
        checks++; if (stall_cnt !== m_cnt || m_cnt == 32'd0) begin errors++; $display("FAIL ar_pre_cnt: got %0d exp %0d", stall_cnt, m_cnt); end
        idle(); #2; rstn = 1'b0; #1;
        checks++; if (RD1_q !== 32'd0 || RD2_q !== 32'd0 || rs1_q !== 5'd0 || rs2_q !== 5'd0) begin
            errors++; $display("FAIL ar_q: got %h %h %0d %0d exp all 0", RD1_q, RD2_q, rs1_q, rs2_q); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL ar_cnt: got %0d exp 0", stall_cnt); end
        RFWr = 1'b1; A3 = 5'd9; WD = 32'h0BAD_F00D; A1 = 5'd9; #1;
        checks++; if (RD1 !== 32'h0BAD_F00D) begin errors++; $display("FAIL ar_bypass: got %h exp 0badf00d", RD1); end
        @(posedge clk); #1;
        idle(); rstn = 1'b1; model_reset(); A1 = 5'd9; A2 = 5'd5; #1;
        checks++; if (RD1 !== 32'd0 || RD2 !== 32'd0) begin errors++; $display("FAIL ar_after: got %h %h exp 0 0", RD1, RD2); end
        clk_edge();
        checks++; if (rs1_q !== 5'd9 || rs2_q !== 5'd5 || RD1_q !== 32'd0) begin
            errors++; $display("FAIL ar_capture: got %0d %0d %h exp 9 5 0", rs1_q, rs2_q, RD1_q); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_x0();
        test_bypass();
        test_load_use();
        test_flush();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
